// File: rtl/pkt_h.sv
// Shared packet types: the pkHeadInfo header, the enqueue arbiter's held-entry
// record, and its output-register state encoding.
package pkt_h;

  localparam int PKT_ARB_MAX_REQ = 16;

  typedef struct packed {
    logic [7:0]  prio;
    logic [7:0]  flow_id;
    logic [15:0] pkt_len;
  } pkHeadInfo;

  typedef struct packed {
    pkHeadInfo   info;
    logic [63:0] data;
    logic [3:0]  src;
  } pkt_arb_entry_t;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/pkt_enq_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr,
// wrapping modulo NUM_REQ.
module pkt_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any_valid
);

  always_comb begin
    int j;
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // wrap by subtraction so non-power-of-2 counts never yield an index >= NUM_REQ
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_valid && req[j]) begin
        any_valid = 1'b1;
        grant[j]  = 1'b1;
        idx       = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/pkt_enq_arbiter.sv
// Round-robin arbiter feeding the single pkt_Priorer enqueue port through a
// one-entry output register. Optional counters under PKT_ARB_STATS_EN.
module pkt_enq_arbiter
  import pkt_h::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DWIDTH  = 64,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  pkHeadInfo [NUM_REQ-1:0]        req_info,
  input  logic [NUM_REQ-1:0][DWIDTH-1:0] req_data,
  input  logic                           prio_ready,
  output logic                           prio_en,
  output pkHeadInfo                      prio_info,
  output logic [DWIDTH-1:0]              prio_data,
  output logic [IDX_W-1:0]               prio_src
`ifdef PKT_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][31:0]       grant_cnt,
  output logic [31:0]                    stall_cnt
`endif
);

  arb_state_e         state, state_nxt;
  pkt_arb_entry_t     entry;
  logic [IDX_W-1:0]   rr_ptr, win_idx;
  logic [NUM_REQ-1:0] win_grant;
  logic               any_valid, load, take;
  logic               unused_entry_bits;

  pkt_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (win_grant),
    .idx       (win_idx),
    .any_valid (any_valid)
  );

  // load covers both an empty register and a drain in the same cycle
  always_comb begin
    load      = (state == ARB_EMPTY) || prio_ready;
    take      = load && any_valid && !rst;
    state_nxt = state;
    req_ready = '0;
    if (load) state_nxt = any_valid ? ARB_FULL : ARB_EMPTY;
    if (take) req_ready = win_grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ARB_EMPTY;
      entry  <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        entry.info <= req_info[win_idx];
        entry.data <= 64'(req_data[win_idx]);
        entry.src  <= 4'(win_idx);
        rr_ptr     <= (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + IDX_W'(1);
      end
    end
  end

  assign prio_en           = (state == ARB_FULL);
  assign prio_info         = entry.info;
  assign prio_data         = entry.data[DWIDTH-1:0];
  assign prio_src          = entry.src[IDX_W-1:0];
  assign unused_entry_bits = ^{entry.data, entry.src};

`ifdef PKT_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (take) grant_cnt[win_idx] <= grant_cnt[win_idx] + 32'd1;
      if (prio_en && !prio_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pkt_enq_arbiter.sv
// Directed + randomized bench for pkt_enq_arbiter against a behavioural
// held-entry / rotating-pointer reference model.
module tb_pkt_enq_arbiter;
  import pkt_h::*;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int IW = 2;

  logic                 clk, rst;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  pkHeadInfo [N-1:0]    req_info;
  logic [N-1:0][DW-1:0] req_data;
  logic                 prio_ready;
  logic                 prio_en;
  pkHeadInfo            prio_info;
  logic [DW-1:0]        prio_data;
  logic [IW-1:0]        prio_src;
`ifdef PKT_ARB_STATS_EN
  logic [N-1:0][31:0]   grant_cnt;
  logic [31:0]          stall_cnt;
`endif

  pkt_enq_arbiter #(.NUM_REQ(N), .DWIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_info(req_info), .req_data(req_data), .prio_ready(prio_ready),
    .prio_en(prio_en), .prio_info(prio_info), .prio_data(prio_data), .prio_src(prio_src)
`ifdef PKT_ARB_STATS_EN
    , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // source side: each pending packet stays put until accepted
  bit          pend [N];
  pkHeadInfo   p_info [N];
  logic [63:0] p_data [N];

  // reference model
  bit          m_full;
  pkHeadInfo   m_info;
  logic [63:0] m_data;
  int          m_src, m_ptr, m_stall;
  int          m_grant [N];
  logic [N-1:0] obs_rdy;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_full = 0; m_ptr = 0; m_src = 0; m_stall = 0;
    for (int i = 0; i < N; i++) m_grant[i] = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_info[i]  = p_info[i];
      req_data[i]  = p_data[i];
    end
  endtask

  task automatic set_src(input int i, input logic [63:0] d);
    if (!pend[i]) begin
      pend[i]   = 1;
      p_info[i] = pkHeadInfo'($urandom);
      p_data[i] = d;
    end
  endtask

  task automatic refill(input int pct);
    for (int i = 0; i < N; i++)
      if ($urandom_range(99) < pct) set_src(i, {$urandom, $urandom});
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // one clock: drive at negedge, check before posedge, advance model, return at negedge
  task automatic cyc(input bit pr);
    int w;
    bit load;
    logic [N-1:0] er;
    prio_ready = pr;
    drive();
    #1;
    load = !m_full || pr;
    w = load ? pick() : -1;
    er = (w >= 0) ? N'(1 << w) : '0;
    obs_rdy = req_ready;
    chk("req_ready", req_ready, er);
    chk("prio_en", prio_en, m_full);
    if (m_full) begin
      chk("prio_info", prio_info, m_info);
      chk("prio_data", prio_data, m_data);
      chk("prio_src", prio_src, m_src);
    end
    @(posedge clk);
    if (m_full && !pr) m_stall++;
    if (load) begin
      if (w >= 0) begin
        m_full = 1; m_info = p_info[w]; m_data = p_data[w]; m_src = w;
        m_ptr = (w + 1) % N; pend[w] = 0; m_grant[w]++;
      end else m_full = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] sd;
    rst = 1'b1;
    prio_ready = 1'b1;
    for (int i = 0; i < N; i++) pend[i] = 0;
    refill(100);
    drive();
    model_reset();
    #1;
    chk("rst_prio_en", prio_en, 1'b0);
    chk("rst_prio_info", prio_info, '0);
    chk("rst_prio_data", prio_data, '0);
    chk("rst_prio_src", prio_src, '0);
    chk("rst_req_ready", req_ready, '0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 0;

    // single source 2
    for (int c = 0; c < 6; c++) begin
      set_src(2, 64'd114514);
      cyc(1'b1);
      chk("single_rdy", obs_rdy, 4'b0100);
      chk("single_en", prio_en, 1'b1);
      chk("single_data", prio_data, 64'd114514);
      chk("single_src", prio_src, 2'd2);
    end

    // all four continuously valid
    do_reset();
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int c = 0; c < 16; c++) begin
      refill(100);
      cyc(1'b1);
      chk("rr_order", prio_src, c % N);
    end
`ifdef PKT_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("rr_grant_cnt", grant_cnt[i], 32'd4);
`endif

    // backpressure with source 1 held
    do_reset();
    for (int i = 0; i < N; i++) pend[i] = 0;
    set_src(1, 64'hA5A5_0001_DEAD_BEEF);
    sd = p_data[1];
    cyc(1'b1);
    refill(100);
    for (int c = 0; c < 5; c++) begin
      cyc(1'b0);
      chk("bp_rdy", obs_rdy, '0);
      chk("bp_src", prio_src, 2'd1);
      chk("bp_data", prio_data, sd);
    end
    cyc(1'b1);
    chk("bp_release_rdy", obs_rdy, 4'b0100);
    chk("bp_release_src", prio_src, 2'd2);

    // drain and load in the same cycle
    for (int i = 0; i < N; i++) pend[i] = 0;
    set_src(3, 64'h0000_3333_CAFE_F00D);
    sd = p_data[3];
    cyc(1'b1);
    chk("dl_rdy", obs_rdy, 4'b1000);
    chk("dl_en", prio_en, 1'b1);
    chk("dl_src", prio_src, 2'd3);
    chk("dl_data", prio_data, sd);

    // randomized traffic
    do_reset();
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int c = 0; c < 400; c++) begin
      refill(40);
      cyc($urandom_range(3) != 0);
    end
`ifdef PKT_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("rand_grant_cnt", grant_cnt[i], m_grant[i]);
    chk("rand_stall_cnt", stall_cnt, m_stall);
`endif

    // asynchronous reset between edges while FULL
    refill(100);
    cyc(1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_en", prio_en, 1'b0);
    chk("arst_src", prio_src, '0);
    chk("arst_rdy", req_ready, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    pend[0] = 0; pend[2] = 0;
    set_src(1, {$urandom, $urandom});
    set_src(3, {$urandom, $urandom});
    cyc(1'b1);
    chk("arst_first_rdy", obs_rdy, 4'b0010);
    chk("arst_first_src", prio_src, 2'd1);

`ifdef PKT_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int c = 0; c < 10; c++) begin
      set_src(0, {$urandom, $urandom});
      cyc(1'b1);
    end
    set_src(0, {$urandom, $urandom});
    for (int c = 0; c < 3; c++) cyc(1'b0);
    chk("stats_grant0", grant_cnt[0], 32'd10);
    chk("stats_stall", stall_cnt, 32'd3);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
